i2s_tx: RTL and testbench

I2S serial transmitter, the transmit-side counterpart of `i2s_rx`. It accepts left/right sample pairs through a valid/ready handshake into a one-deep holding buffer. Each pair is serialised MSB-first onto `sd`, timed by the shared bit-clock enable and the `frame_posn` counter from the I2S clock generator. It sits between the DSP output path and the codec/DAC data pin, and its frame alignment matches `i2s_rx` so a loopback recovers the sent words.

---
 rtl/i2s_tx.sv | 98 +++++++++
 tb/tb_i2s_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S serial transmitter with one-deep sample-pair holding buffer
module i2s_tx #(
    parameter int BITS   = 24,
    parameter int CLOCKS = 64
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            en,
    input  logic [5:0]      frame_posn,
    input  logic [BITS-1:0] left,
    input  logic [BITS-1:0] right,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            sd,
    output logic            frame_start,
    output logic            underrun
);

    localparam int HALF = CLOCKS / 2;

    logic [BITS-1:0]   hold_l_q, hold_l_d;
    logic [BITS-1:0]   hold_r_q, hold_r_d;
    logic              full_q, full_d;
    logic [CLOCKS-1:0] shift_q, shift_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;

    logic [5:0]        p;
    logic              load;
    logic              accept;
    logic [HALF-1:0]   l_slot;
    logic [HALF-1:0]   r_slot;

    assign p        = frame_posn & 6'(CLOCKS - 1);
    assign load     = en && (p == 6'd1);
    assign in_ready = !full_q && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        l_slot = '0;
        r_slot = '0;
        l_slot[HALF-1 -: BITS] = hold_l_q;
        r_slot[HALF-1 -: BITS] = hold_r_q;

        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        full_d        = full_q;
        shift_d       = shift_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (en) begin
            if (load) begin
                frame_start_d = 1'b1;
                full_d        = 1'b0;
                if (full_q) begin
                    shift_d = {l_slot, r_slot};
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[CLOCKS-2:0], 1'b0};
            end
        end

        // A pair written in the load cycle lands after the load has drained
        // the buffer, so it is held for the following frame.
        if (accept) begin
            hold_l_d = left;
            hold_r_d = right;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            full_q        <= 1'b0;
            shift_q       <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            full_q        <= full_d;
            shift_q       <= shift_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sd          = shift_q[CLOCKS-1];
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench for i2s_tx in 24/64 and 16/32 configurations
module tb_i2s_tx;

    localparam int DIV = 4;
    localparam int BOUND = 4 * 64 * DIV;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [5:0]  frame_posn = 6'd50;
    logic [1:0]  div_q = 2'd0;

    logic        in_valid_a = 1'b0;
    logic [23:0] left_a = '0, right_a = '0;
    logic        in_ready_a, sd_a, fs_a, ur_a;

    logic        in_valid_b = 1'b0;
    logic [15:0] left_b = '0, right_b = '0;
    logic        in_ready_b, sd_b, fs_b, ur_b;

    logic [63:0] q64[$];
    logic [31:0] q32[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 ck = ~ck;

    always @(posedge ck) begin
        if (div_q == 2'(DIV - 1)) begin
            div_q      <= 2'd0;
            frame_posn <= frame_posn + 6'd1;
            en         <= 1'b1;
        end else begin
            div_q <= div_q + 2'd1;
            en    <= 1'b0;
        end
    end

    i2s_tx #(.BITS(24), .CLOCKS(64)) u_a (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn),
        .left(left_a), .right(right_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .sd(sd_a), .frame_start(fs_a), .underrun(ur_a)
    );

    i2s_tx #(.BITS(16), .CLOCKS(32)) u_b (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn),
        .left(left_b), .right(right_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sd(sd_b), .frame_start(fs_b), .underrun(ur_b)
    );

    // Stops in the cycle before a load edge (en high with p == 1).
    task automatic wait_load(input bit c32, output bit ok);
        logic [5:0] pp;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            pp = c32 ? {1'b0, frame_posn[4:0]} : frame_posn;
            if (en && pp == 6'd1) begin
                ok = 1'b1;
                break;
            end
            @(posedge ck); #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL load_timeout: no load point seen, required one within %0d cycles", BOUND);
        end
    endtask

    task automatic write_pair(input bit c32, input logic [23:0] l, input logic [23:0] r);
        bit rdy = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            rdy = c32 ? in_ready_b : in_ready_a;
            if (rdy) break;
            @(posedge ck); #1;
        end
        n_checks++;
        if (!rdy) $display("FAIL write_ready: in_ready=0 required 1 (c32=%0d)", c32);
        else n_pass++;
        if (c32) begin
            in_valid_b = 1'b1; left_b = l[15:0]; right_b = r[15:0];
        end else begin
            in_valid_a = 1'b1; left_a = l; right_a = r;
        end
        @(posedge ck); #1;
        if (rdy) begin
            if (c32) q32.push_back({l[15:0], r[15:0]});
            else     q64.push_back({l, 8'h00, r, 8'h00});
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        n_checks++;
        if ((c32 ? in_ready_b : in_ready_a) !== 1'b0)
            $display("FAIL write_ready_fall: in_ready=%b required 0 after capture", c32 ? in_ready_b : in_ready_a);
        else n_pass++;
    endtask

    // Captures one frame from the load edge; optionally writes a pair in the load cycle.
    task automatic capture_frame(input bit c32, input bit wr, input logic [23:0] wl,
                                 input logic [23:0] wrr, output logic [63:0] got);
        bit ok, rdy, exp_ur;
        logic [63:0] exp;
        int n;
        n = c32 ? 32 : 64;
        got = '0;
        wait_load(c32, ok);
        if (!ok) return;
        if (c32) begin
            if (q32.size() > 0) begin exp = {32'h0, q32.pop_front()}; exp_ur = 1'b0; end
            else begin exp = '0; exp_ur = 1'b1; end
        end else begin
            if (q64.size() > 0) begin exp = q64.pop_front(); exp_ur = 1'b0; end
            else begin exp = '0; exp_ur = 1'b1; end
        end
        rdy = 1'b0;
        if (wr) begin
            rdy = in_ready_a;
            in_valid_a = 1'b1; left_a = wl; right_a = wrr;
        end
        @(posedge ck); #1;
        if (wr) begin
            if (rdy) q64.push_back({wl, 8'h00, wrr, 8'h00});
            in_valid_a = 1'b0;
        end
        n_checks++;
        if ((c32 ? fs_b : fs_a) !== 1'b1) $display("FAIL frame_start: got %b required 1", c32 ? fs_b : fs_a);
        else n_pass++;
        n_checks++;
        if ((c32 ? ur_b : ur_a) !== exp_ur) $display("FAIL underrun: got %b required %b", c32 ? ur_b : ur_a, exp_ur);
        else n_pass++;
        for (int k = 0; k < n; k++) begin
            got[n-1-k] = c32 ? sd_b : sd_a;
            if (k == 0) begin
                @(posedge ck); #1;
                n_checks++;
                if ((c32 ? {fs_b, ur_b} : {fs_a, ur_a}) !== 2'b00)
                    $display("FAIL pulse_width: frame_start/underrun=%b required 00", c32 ? {fs_b, ur_b} : {fs_a, ur_a});
                else n_pass++;
                repeat (DIV - 1) begin @(posedge ck); #1; end
            end else if (k < n - 1) begin
                repeat (DIV) begin @(posedge ck); #1; end
            end
        end
        n_checks++;
        if (got !== exp) $display("FAIL frame_bits: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge ck); #1; end
        n_checks++;
        if ({sd_a, fs_a, ur_a, in_ready_a, sd_b, in_ready_b} !== 6'b0)
            $display("FAIL reset_state: sd/fs/ur/rdy/sd_b/rdy_b=%b required 000000",
                     {sd_a, fs_a, ur_a, in_ready_a, sd_b, in_ready_b});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready_a, in_ready_b} !== 2'b11) $display("FAIL reset_ready: got %b required 11", {in_ready_a, in_ready_b});
        else n_pass++;
    endtask

    task automatic test_frames64();
        logic [23:0] tl[4], tr[4];
        logic [15:0] l16[4], r16[4];
        logic [63:0] got;
        tl  = '{24'hf0f0f0, 24'h123456, 24'h000000, 24'h555555};
        tr  = '{24'hcafedb, 24'hffffff, 24'haaaaaa, 24'h123456};
        l16 = '{16'hf0f0, 16'h1234, 16'h0000, 16'h5555};
        r16 = '{16'hcafe, 16'hffff, 16'haaaa, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            write_pair(1'b0, tl[i], tr[i]);
            capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
            n_checks++;
            if ({got[63:48], got[31:16]} !== {l16[i], r16[i]})
                $display("FAIL rx16_%0d: got %h/%h required %h/%h", i, got[63:48], got[31:16], l16[i], r16[i]);
            else n_pass++;
        end
    endtask

    task automatic test_placement();
        logic [63:0] got;
        int bad = 0;
        bit want;
        write_pair(1'b0, 24'h800001, 24'h800001);
        capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
        for (int p = 0; p < 64; p++) begin
            want = (p == 1 || p == 24 || p == 33 || p == 56);
            if (got[63 - ((p + 63) % 64)] !== want) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL placement: %0d slots wrong in %h, required ones only at p=1,24,33,56", bad, got);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [63:0] got;
        capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
    endtask

    task automatic test_frames32();
        logic [15:0] tl[4], tr[4];
        logic [63:0] got;
        tl = '{16'hface, 16'hffff, 16'h0000, 16'haaaa};
        tr = '{16'h1234, 16'h0000, 16'hffff, 16'h5555};
        for (int i = 0; i < 4; i++) begin
            write_pair(1'b1, {8'h0, tl[i]}, {8'h0, tr[i]});
            capture_frame(1'b1, 1'b0, 24'h0, 24'h0, got);
            n_checks++;
            if (got[31:0] !== {tl[i], tr[i]})
                $display("FAIL rx32_%0d: got %h/%h required %h/%h", i, got[31:16], got[15:0], tl[i], tr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_handshake();
        bit ok, full_m, is_load, done;
        int v = 0, accepted = 0, loads = 0, ready_bad = 0;
        logic [23:0] last_l = '0;
        logic [63:0] got;
        wait_load(1'b0, ok);
        if (q64.size() > 0) void'(q64.pop_front());
        @(posedge ck); #1;
        full_m = 1'b0;
        done = 1'b0;
        in_valid_a = 1'b1;
        for (int i = 0; i < BOUND && !done; i++) begin
            left_a  = 24'h100000 + 24'(v);
            right_a = 24'h200000 + 24'(v);
            if (in_ready_a !== !full_m) ready_bad++;
            is_load = en && frame_posn == 6'd1;
            if (is_load) begin
                if (q64.size() > 0) void'(q64.pop_front());
                loads++;
            end
            @(posedge ck); #1;
            if (!full_m) begin
                q64.push_back({left_a, 8'h00, right_a, 8'h00});
                accepted++;
                last_l = left_a;
                if (loads == 1) done = 1'b1;
                full_m = 1'b1;
            end else if (is_load) begin
                full_m = 1'b0;
            end
            v++;
        end
        in_valid_a = 1'b0;
        n_checks++;
        if (ready_bad != 0) $display("FAIL hs_ready: %0d cycles with wrong in_ready", ready_bad);
        else n_pass++;
        n_checks++;
        if (accepted != 2 || loads != 1) $display("FAIL hs_count: accepted %0d over %0d loads, required 2 over 1", accepted, loads);
        else n_pass++;
        capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
        n_checks++;
        if (got[63:40] !== last_l) $display("FAIL hs_next_frame: left %h required %h", got[63:40], last_l);
        else n_pass++;
    endtask

    task automatic test_load_collision();
        logic [63:0] got;
        capture_frame(1'b0, 1'b1, 24'h0badc0, 24'h0ffee1, got);
        capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
        n_checks++;
        if ({got[63:40], got[31:8]} !== {24'h0badc0, 24'h0ffee1})
            $display("FAIL collision_next: got %h/%h required 0badc0/0ffee1", got[63:40], got[31:8]);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int bad = 0;
        logic [63:0] got;
        write_pair(1'b0, 24'ha5a5a5, 24'h5a5a5a);
        wait_load(1'b0, ok);
        if (q64.size() > 0) void'(q64.pop_front());
        @(posedge ck); #1;
        for (int i = 0; i < BOUND; i++) begin
            if (frame_posn == 6'd10) break;
            @(posedge ck); #1;
        end
        rst = 1'b1;
        @(posedge ck); #1;
        q64.delete();
        q32.delete();
        n_checks++;
        if ({sd_a, in_ready_a, fs_a, ur_a} !== 4'b0000)
            $display("FAIL midreset_state: sd/rdy/fs/ur=%b required 0000", {sd_a, in_ready_a, fs_a, ur_a});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_a !== 1'b1) $display("FAIL midreset_ready: got %b required 1", in_ready_a);
        else n_pass++;
        for (int i = 0; i < BOUND; i++) begin
            if (en && frame_posn == 6'd1) break;
            if (sd_a !== 1'b0) bad++;
            @(posedge ck); #1;
        end
        n_checks++;
        if (bad != 0) $display("FAIL midreset_quiet: sd high in %0d cycles, required 0", bad);
        else n_pass++;
        capture_frame(1'b0, 1'b0, 24'h0, 24'h0, got);
    endtask

    initial begin
        test_reset();
        test_frames64();
        test_placement();
        test_underrun();
        test_frames32();
        test_handshake();
        test_load_collision();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
